// File: rtl/memory_pkg.sv
// Shared constants for the memory block: default geometry and the power-up preload table.
// The preload table is only used when MEMORY_PRELOAD_EN is defined.
package memory_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    localparam int PRELOAD_ADDR0 = 0;
    localparam int PRELOAD_ADDR1 = 1;
    localparam int PRELOAD_ADDR2 = 2;
    localparam int PRELOAD_ADDR3 = 3;

    localparam logic [15:0] PRELOAD_DATA0 = 16'h1234;
    localparam logic [15:0] PRELOAD_DATA1 = 16'h1337;
    localparam logic [15:0] PRELOAD_DATA2 = 16'hDEAD;
    localparam logic [15:0] PRELOAD_DATA3 = 16'hBEEF;

endpackage

// File: rtl/memory_array.sv
// Storage array with one synchronous write port and an asynchronous read of a registered address.
// Define MEMORY_PRELOAD_EN to power up with the preload table; otherwise all words power up as 0.
module memory_array
    import memory_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int AW = ADDR_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    // Contents are set only at power-up/configuration; reset never touches them.
`ifdef MEMORY_PRELOAD_EN
    logic [DW-1:0] mem [DEPTH] = '{
        PRELOAD_ADDR0: DW'(PRELOAD_DATA0),
        PRELOAD_ADDR1: DW'(PRELOAD_DATA1),
        PRELOAD_ADDR2: DW'(PRELOAD_DATA2),
        PRELOAD_ADDR3: DW'(PRELOAD_DATA3),
        default:       '0
    };
`else
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
`endif

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory.sv
// Single-port synchronous RAM: registered address, 1-cycle read latency, write-first.
// Storage power-up contents follow MEMORY_PRELOAD_EN (see memory_array).
module memory
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rdata;

    // rd_vld forces q to 0 from reset assertion until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rd_vld <= 1'b0;
        end else begin
            addr_q <= addr;
            rd_vld <= 1'b1;
        end
    end

    // Reading the address registered on the same edge as the write gives write-first behaviour.
    memory_array #(
        .DW(DATA_WIDTH),
        .AW(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we & rst_n),
        .waddr (addr),
        .wdata (data),
        .raddr (addr_q),
        .rdata (rdata)
    );

    assign q = rd_vld ? rdata : '0;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios plus random traffic against an array model.
// Preload expectations follow MEMORY_PRELOAD_EN.
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [9:0]  addr;
    logic        we;
    logic [15:0] q;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [1024];
    logic [15:0] exp_q;

    memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .addr  (addr),
        .we    (we),
        .q     (q)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // One clock: drive at the falling edge, apply model at the rising edge, return at the next falling edge.
    task automatic cyc(input logic [9:0] a, input logic [15:0] d, input logic w);
        addr = a;
        data = d;
        we   = w;
        @(posedge clk);
        if (rst_n && w) model[a] = d;
        exp_q = rst_n ? model[a] : 16'h0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr  = 10'h3;
        data  = 16'h0;
        we    = 1'b0;
        #10;
        checks++;
        if (q !== 16'h0) begin
            errors++;
            $display("FAIL reset_q: got %h want 0000", q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 4; i++) begin
            cyc(10'(i), 16'h0, 1'b0);
            checks++;
            if (q !== exp_q) begin
                errors++;
                $display("FAIL preload_read[%0d]: got %h want %h", i, q, exp_q);
            end
        end
    endtask

    task automatic test_write_first();
        cyc(10'h3, 16'h1111, 1'b1);
        checks++;
        if (q !== 16'h1111) begin
            errors++;
            $display("FAIL write_first: got %h want 1111", q);
        end
        cyc(10'h3, 16'h2222, 1'b0);
        checks++;
        if (q !== 16'h1111) begin
            errors++;
            $display("FAIL hold_after_write: got %h want 1111", q);
        end
    endtask

    task automatic test_boundary();
        cyc(10'h3FF, 16'hA5A5, 1'b1);
        cyc(10'h000, 16'h5A5A, 1'b1);
        cyc(10'h3FF, 16'h0, 1'b0);
        checks++;
        if (q !== 16'hA5A5) begin
            errors++;
            $display("FAIL boundary_top: got %h want a5a5", q);
        end
        cyc(10'h000, 16'h0, 1'b0);
        checks++;
        if (q !== 16'h5A5A) begin
            errors++;
            $display("FAIL boundary_zero: got %h want 5a5a", q);
        end
        cyc(10'h1FF, 16'h0, 1'b0);
        checks++;
        if (q !== model[10'h1FF]) begin
            errors++;
            $display("FAIL boundary_alias: got %h want %h", q, model[10'h1FF]);
        end
    endtask

    task automatic test_reset_midwrite();
        cyc(10'h3, 16'hBEEF, 1'b1);
        cyc(10'h3, 16'h0, 1'b0);
        checks++;
        if (q !== 16'hBEEF) begin
            errors++;
            $display("FAIL pre_reset_q: got %h want beef", q);
        end
        addr = 10'h2;
        data = 16'hFFFF;
        we   = 1'b1;
        #25;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_q: got %h want 0000", q);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (q !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold_q: got %h want 0000", q);
        end
        rst_n = 1'b1;
        cyc(10'h2, 16'h0, 1'b0);
        checks++;
        if (q !== model[2]) begin
            errors++;
            $display("FAIL write_during_reset: got %h want %h", q, model[2]);
        end
        cyc(10'h3, 16'h0, 1'b0);
        checks++;
        if (q !== 16'hBEEF) begin
            errors++;
            $display("FAIL reset_keeps_storage: got %h want beef", q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cyc(10'(100 + i), 16'(16'hC000 + i * 3), 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(10'(100 + i), 16'h0, 1'b0);
            checks++;
            if (q !== 16'(16'hC000 + i * 3)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, q, 16'(16'hC000 + i * 3));
            end
        end
    endtask

    task automatic test_random();
        logic [9:0]  a;
        logic [15:0] d;
        logic        w;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
            d = 16'($urandom);
            w = ($urandom_range(0, 2) == 0);
            cyc(a, d, w);
            checks++;
            if (q !== exp_q) begin
                errors++;
                $display("FAIL random[%0d] addr=%h we=%b: got %h want %h", i, a, w, q, exp_q);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 16'h0;
`ifdef MEMORY_PRELOAD_EN
        model[0] = 16'h1234;
        model[1] = 16'h1337;
        model[2] = 16'hDEAD;
        model[3] = 16'hBEEF;
`endif
        test_reset();
        test_preload();
        test_write_first();
        test_boundary();
        test_reset_midwrite();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, which sets the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, which sets the address width; depth is 2**ADDR_WIDTH words (1024 by default).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, with all sequential logic on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port data SHALL be an input, DATA_WIDTH bits: the write data.
REQ-006 Port addr SHALL be an input, ADDR_WIDTH bits: the word address for both read and write.
REQ-007 Port we SHALL be an input, 1 bit: the write enable, active-high.
REQ-008 Port q SHALL be an output, DATA_WIDTH bits: the registered read data.

Function
REQ-009 The block SHALL be a single-port synchronous RAM with one shared address for read and write.
REQ-010 On each rising clk edge with rst_n high, addr SHALL be registered, and q SHALL equal the word at the registered address; read latency is 1 cycle.
REQ-011 On a rising clk edge with we=1 and rst_n high, data SHALL be written to word addr.
REQ-012 Read-during-write at the same address SHALL be write-first: after the edge, q shows the newly written data.
REQ-013 With we=0, the storage contents SHALL be unchanged, and q SHALL track the word at the last registered address.
REQ-014 Every address from 0 to 2**ADDR_WIDTH-1 SHALL be valid; the address SHALL NOT wrap or alias below full depth.
REQ-015 If addr, data and we are held constant, q SHALL stay stable and SHALL NOT glitch between edges.
REQ-016 Storage contents SHALL persist indefinitely, with no refresh and no clearing except as stated under Configuration.

Reset
REQ-017 While rst_n=0, q SHALL be 0 asynchronously, and the registered address SHALL be 0.
REQ-018 Reset SHALL NOT alter storage contents.
REQ-019 While rst_n=0, writes SHALL be ignored.
REQ-020 If reset is asserted mid-write, that edge's write SHALL be dropped.
REQ-021 On the first rising edge after rst_n deasserts, q SHALL equal the word at the addr presented on that edge.

Configuration
REQ-022 When macro MEMORY_PRELOAD_EN is defined, the storage SHALL power up with word 0=16'h1234, 1=16'h1337, 2=16'hDEAD, 3=16'hBEEF, and all other words 0.
REQ-023 When MEMORY_PRELOAD_EN is not defined, every word SHALL power up as 0.
REQ-024 The preload SHALL apply only at configuration or power-up, never on rst_n.

Structure
REQ-025 A shared package memory_pkg SHALL hold the default DATA_WIDTH and ADDR_WIDTH constants and the preload table (address/value constants).
REQ-026 Sub-module memory_array SHALL hold the storage array, the write port and the preload.
REQ-027 The top level memory SHALL hold the address/output register and the reset logic.

Verification (MEMORY_PRELOAD_EN defined, default parameters, 100-time-unit clock)
REQ-028 Reset pulse, then addr=0, we=0, one clock -> q=16'h1234.
REQ-029 Continuing from REQ-028: addr=1, then 2, then 3, one clock each -> q=16'h1337, 16'hDEAD, 16'hBEEF respectively.
REQ-030 addr=3, data=16'h1111, we=1, one clock -> q=16'h1111 (write-first); then we=0, addr=3 -> q stays 16'h1111.
REQ-031 Write 16'hA5A5 to addr=10'h3FF and 16'h5A5A to addr 0, then read both -> q=16'hA5A5 and 16'h5A5A; no aliasing.
REQ-032 Assert rst_n=0 mid-cycle while q=16'hBEEF -> q=0 immediately; a write attempted during reset is lost; after release, addr=2 -> q=16'hDEAD.
REQ-033 Build without MEMORY_PRELOAD_EN, read addr 0-3 -> q=0 for each.
